uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares one uart_tx instance between N_REQ byte producers (CPU core, debug/monitor, status reporter, ...). Round-robin arbitration per byte, with an optional lock that holds ownership across a multi-byte message. Generates the uart_tx en/data_in strobe and sequences on its rdy, so requesters never touch the UART directly.

Parameters:
N_REQ, 4, number of requesters (2..8)
DATA_W, 8, byte width presented to uart_tx
BUSY_TIMEOUT, 4, max cycles to wait for uart_rdy to fall after an en pulse

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  N_REQ  requester i has a byte pending
req_data  in  N_REQ*DATA_W  byte of requester i at bits [i*DATA_W +: DATA_W]
req_lock  in  N_REQ  sampled with the accepted byte; 1 = more bytes of this message follow
req_ready  out  N_REQ  byte accepted this cycle (at most one bit set)
grant  out  N_REQ  one-hot current/last owner, 0 when no owner
uart_en  out  1  one-cycle start strobe to uart_tx en
uart_data  out  DATA_W  to uart_tx data_in, held stable between accepts
uart_rdy  in  1  uart_tx rdy (1 = idle)
busy  out  1  state != IDLE or lock held

Behaviour:
- Reset (async, rst_n=0): state IDLE, uart_en=0, uart_data=0, grant=0, lock flag=0, RR pointer=0. Applies mid-transfer; a byte in flight in uart_tx is not aborted by this block.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE: eligible set = req_valid, restricted to owner bit if lock flag set. If uart_rdy=1 and eligible non-empty, winner = first eligible at or after RR pointer (wrapping). req_ready[winner]=1 combinationally that same cycle (cycle T); transfer occurs on valid&ready. At T edge: uart_data<=req_data[winner], grant<=onehot(winner), lock flag<=req_lock[winner], state->ISSUE.
- RR pointer: after accepting an unlocked byte (req_lock=0), pointer<=winner+1 mod N_REQ; while lock flag set, pointer unchanged.
- ISSUE (T+1): uart_en=1 for exactly this cycle; state->WAIT_BUSY.
- WAIT_BUSY: leave to WAIT_DONE on first cycle uart_rdy=0, or after BUSY_TIMEOUT cycles in state (covers UARTs that never drop rdy). Counter width clog2(BUSY_TIMEOUT+1).
- WAIT_DONE: on uart_rdy=1 -> IDLE. Earliest next accept is the cycle after returning to IDLE.
- req_ready is 0 in every state except IDLE; never two bits set.
- Locked owner with req_valid=0: others stall indefinitely (no lock timeout); the lock is released only by an accepted byte with req_lock=0.
- grant retains the last owner after unlocked completion until the next accept; cleared only by reset.
- uart_rdy=0 while in IDLE (external activity or post-reset busy UART): no accept, no stall of state.
- req_valid may drop without a transfer; no side effect.
- Throughput: one byte per uart frame + 3 cycles overhead (accept, ISSUE, return).

Decomposition:
- Package uart_arb_pkg: state enum (IDLE, ISSUE, WAIT_BUSY, WAIT_DONE), default N_REQ/DATA_W/BUSY_TIMEOUT constants.
- Sub-module rr_pick: combinational round-robin picker (req vector, pointer -> one-hot winner, valid flag). FSM, timers and data latch stay in uart_tx_arbiter.

Test Plan:
- Single req0 sends 0x41, model UART rdy low 10 cycles -> req_ready[0] one cycle, uart_en one cycle later with uart_data=0x41, next accept only after rdy returns.
- req0..req3 all valid continuously, bytes 0x10..0x13, lock=0 -> UART sees 0x10,0x11,0x12,0x13,0x10,... strict rotation.
- req2 sends 0xA0,0xA1,0xA2 with lock=1,1,0 while req0 valid with 0x55 -> UART sees A0 A1 A2 then 55; req_ready[0] never asserted during lock.
- Stub UART with rdy stuck at 1 -> uart_en pulses every BUSY_TIMEOUT+3 cycles, no deadlock.
- Locked owner deasserts valid for 20 cycles -> no other grant, busy=1; then sends 0xFF lock=0 -> lock released, next requester served.
- rst_n low during WAIT_BUSY, then req1 sends 0x33 -> immediate outputs 0, grant=0, after release RR starts at req0 and 0x33 issued correctly.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and default sizing for the UART transmit arbiter.
package uart_arb_pkg;

  localparam int unsigned N_REQ_DEF        = 4;
  localparam int unsigned DATA_W_DEF       = 8;
  localparam int unsigned BUSY_TIMEOUT_DEF = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping.
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned IW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [IW-1:0]    idx_o,
  output logic             valid_o
);

  logic [N_REQ-1:0] rot;
  logic [IW-1:0]    off;
  logic             found;
  logic [IW:0]      sum;

  // Rotate so that bit 0 corresponds to the pointer position.
  assign rot = N_REQ'({req_i, req_i} >> ptr_i);

  // Find first set bit of the rotated vector, then map back to a requester index.
  always_comb begin
    found = 1'b0;
    off   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!found && rot[IW'(k)]) begin
        found = 1'b1;
        off   = IW'(k);
      end
    end
    sum = {1'b0, ptr_i} + {1'b0, off};
    if (sum >= (IW+1)'(N_REQ)) begin
      sum = sum - (IW+1)'(N_REQ);
    end
    idx_o   = sum[IW-1:0];
    valid_o = found;
    grant_o = found ? (N_REQ'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between N_REQ byte producers, with message lock.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned N_REQ        = N_REQ_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_lock,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        grant,
  output logic                    uart_en,
  output logic [DATA_W-1:0]       uart_data,
  input  logic                    uart_rdy,
  output logic                    busy
);

  localparam int unsigned IW = $clog2(N_REQ);
  localparam int unsigned CW = $clog2(BUSY_TIMEOUT + 1);

  arb_state_e        state_q;
  logic              uart_en_q;
  logic [DATA_W-1:0] uart_data_q;
  logic [N_REQ-1:0]  grant_q;
  logic              lock_q;
  logic [IW-1:0]     ptr_q;
  logic [CW-1:0]     cnt_q;

  logic [N_REQ-1:0]  eligible_c;
  logic [N_REQ-1:0]  pick_oh_c;
  logic [IW-1:0]     pick_idx_c;
  logic              pick_valid_c;
  logic              accept_c;
  logic [DATA_W-1:0] sel_data_c;
  logic              sel_lock_c;
  logic [IW-1:0]     ptr_next_c;
  logic [DATA_W-1:0] data_arr [N_REQ];

  // Unpack the flat request data bus into one byte per requester.
  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
  end

  // While a message lock is held only the owner may compete.
  assign eligible_c = lock_q ? (req_valid & grant_q) : req_valid;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .req_i   (eligible_c),
    .ptr_i   (ptr_q),
    .grant_o (pick_oh_c),
    .idx_o   (pick_idx_c),
    .valid_o (pick_valid_c)
  );

  assign accept_c   = (state_q == IDLE) && uart_rdy && pick_valid_c;
  assign req_ready  = accept_c ? pick_oh_c : '0;
  assign sel_data_c = data_arr[pick_idx_c];
  assign sel_lock_c = req_lock[pick_idx_c];
  assign ptr_next_c = (pick_idx_c == IW'(N_REQ - 1)) ? '0 : pick_idx_c + IW'(1);

  assign grant     = grant_q;
  assign uart_en   = uart_en_q;
  assign uart_data = uart_data_q;
  assign busy      = (state_q != IDLE) || lock_q;

  // Arbitration FSM: accept a byte, strobe uart_tx, then track its rdy handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      uart_en_q   <= 1'b0;
      uart_data_q <= '0;
      grant_q     <= '0;
      lock_q      <= 1'b0;
      ptr_q       <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_c) begin
            uart_data_q <= sel_data_c;
            grant_q     <= pick_oh_c;
            lock_q      <= sel_lock_c;
            uart_en_q   <= 1'b1;
            if (!sel_lock_c) begin
              ptr_q <= ptr_next_c;
            end
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          uart_en_q <= 1'b0;
          cnt_q     <= '0;
          state_q   <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          // Give up waiting for rdy to drop so a UART that never deasserts cannot deadlock us.
          if (!uart_rdy || (cnt_q == CW'(BUSY_TIMEOUT - 1))) begin
            state_q <= WAIT_DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        WAIT_DONE: begin
          if (uart_rdy) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a behavioural UART and round-robin model.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int BT = 4;
  localparam logic [N-1:0] ONE = 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_lock;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    grant;
  logic            uart_en;
  logic [DW-1:0]   uart_data;
  logic            uart_rdy = 1'b1;
  logic            busy;

  int checks   = 0;
  int failures = 0;

  // UART model settings
  bit u_stuck = 1'b0;
  int u_frame = 10;
  int u_cnt   = 0;

  // Reference model state
  int           m_ptr;
  int           m_owner;
  bit           m_lock;
  bit           acc_prev;
  logic [7:0]   prev_byte;
  int           last_acc;
  logic [7:0]   sent [$];
  int unsigned  q [N][$];

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N_REQ        (N),
    .DATA_W       (DW),
    .BUSY_TIMEOUT (BT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_lock  (req_lock),
    .req_ready (req_ready),
    .grant     (grant),
    .uart_en   (uart_en),
    .uart_data (uart_data),
    .uart_rdy  (uart_rdy),
    .busy      (busy)
  );

  // Behavioural uart_tx: rdy drops the cycle after en and stays low for u_frame cycles.
  always @(posedge clk) begin
    if (u_stuck) begin
      uart_rdy <= 1'b1;
    end else if (uart_en) begin
      uart_rdy <= 1'b0;
      u_cnt    <= u_frame - 1;
    end else if (!uart_rdy) begin
      if (u_cnt == 0) uart_rdy <= 1'b1;
      else            u_cnt    <= u_cnt - 1;
    end
  end

  function automatic int unsigned ent(input logic [7:0] d, input bit l, input int nb);
    return (int'(nb) << 16) | (l ? 32'h100 : 32'h0) | {24'h0, d};
  endfunction

  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (ptr + k) % N;
      if (((v >> idx) & ONE) != '0) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr    = 0;
    m_owner  = -1;
    m_lock   = 1'b0;
    acc_prev = 1'b0;
    last_acc = 0;
    sent.delete();
    for (int i = 0; i < N; i++) q[i].delete();
  endtask

  task automatic do_reset();
    req_valid = '0;
    req_data  = '0;
    req_lock  = '0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  // Drive queued bytes each cycle and compare DUT behaviour against the model.
  task automatic run_traffic(input string tag, input int gap_min, input bit gap_exact,
                             input bit rnd_hold, input int budget);
    int  cyc   = 0;
    int  drain = -1;
    int  nacc  = 0;
    bit  done  = 1'b0;
    acc_prev = 1'b0;
    while (!done) begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        bit          v;
        int unsigned e;
        v = 1'b0;
        e = 0;
        if (q[i].size() > 0) begin
          e = q[i][0];
          v = (cyc >= int'(e >> 16)) && !(rnd_hold && ($urandom_range(0, 3) == 0));
        end
        req_valid[i]          = v;
        req_lock[i]           = e[8];
        req_data[i*DW +: DW]  = e[7:0];
      end
      @(negedge clk);
      begin
        logic [N-1:0] g_exp;
        g_exp = (m_owner < 0) ? '0 : (ONE << m_owner);
        checks++;
        if (uart_en !== acc_prev || (acc_prev && uart_data !== prev_byte)) begin
          failures++;
          $display("FAIL %s uart_strobe cyc=%0d en=%b data=%h expected en=%b data=%h",
                   tag, cyc, uart_en, uart_data, acc_prev, prev_byte);
        end
        if (uart_en === 1'b1) sent.push_back(uart_data);
        checks++;
        if (grant !== g_exp) begin
          failures++;
          $display("FAIL %s grant cyc=%0d got=%b expected=%b", tag, cyc, grant, g_exp);
        end
        if (m_lock) begin
          checks++;
          if (busy !== 1'b1) begin
            failures++;
            $display("FAIL %s busy_locked cyc=%0d got=%b expected=1", tag, cyc, busy);
          end
        end
        acc_prev = 1'b0;
        if (req_ready !== '0) begin
          logic [N-1:0] elig;
          int           w;
          elig = m_lock ? (req_valid & g_exp) : req_valid;
          w    = pick(elig, m_ptr);
          checks++;
          if (w < 0 || req_ready !== (ONE << w)) begin
            failures++;
            $display("FAIL %s winner cyc=%0d req_ready=%b expected_idx=%0d", tag, cyc, req_ready, w);
          end
          checks++;
          if (uart_rdy !== 1'b1) begin
            failures++;
            $display("FAIL %s accept_while_uart_busy cyc=%0d uart_rdy=%b expected=1", tag, cyc, uart_rdy);
          end
          if (nacc > 0) begin
            int gap;
            gap = cyc - last_acc;
            checks++;
            if (gap_exact ? (gap != gap_min) : (gap < gap_min)) begin
              failures++;
              $display("FAIL %s accept_gap cyc=%0d got=%0d expected%s%0d",
                       tag, cyc, gap, gap_exact ? "=" : ">=", gap_min);
            end
          end
          if (w >= 0 && q[w].size() > 0) begin
            int unsigned e;
            e         = q[w].pop_front();
            prev_byte = e[7:0];
            acc_prev  = 1'b1;
            m_owner   = w;
            m_lock    = e[8];
            if (!m_lock) m_ptr = (w + 1) % N;
            last_acc  = cyc;
            nacc++;
          end
        end
      end
      cyc++;
      begin
        bit empty;
        empty = 1'b1;
        for (int i = 0; i < N; i++) if (q[i].size() > 0) empty = 1'b0;
        if (empty) begin
          if (drain < 0) drain = gap_min + 4;
          else           drain--;
          if (drain == 0) done = 1'b1;
        end
      end
      if (!done && cyc > budget) begin
        failures++;
        $display("FAIL %s timeout cyc=%0d budget=%0d", tag, cyc, budget);
        done = 1'b1;
      end
    end
    req_valid = '0;
  endtask

  task automatic check_sent(input string tag, input logic [7:0] exp [$]);
    checks++;
    if (sent.size() != exp.size()) begin
      failures++;
      $display("FAIL %s sent_count got=%0d expected=%0d", tag, sent.size(), exp.size());
    end else begin
      for (int j = 0; j < exp.size(); j++) begin
        checks++;
        if (sent[j] !== exp[j]) begin
          failures++;
          $display("FAIL %s sent[%0d] got=%h expected=%h", tag, j, sent[j], exp[j]);
        end
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if (uart_en !== 1'b0 || uart_data !== '0 || grant !== '0 || busy !== 1'b0 || req_ready !== '0) begin
      failures++;
      $display("FAIL %s reset_outputs en=%b data=%h grant=%b busy=%b ready=%b expected all zero",
               tag, uart_en, uart_data, grant, busy, req_ready);
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    check_idle_outputs("reset");
  endtask

  task automatic test_single();
    logic [7:0] exp [$];
    do_reset();
    u_frame = 10;
    q[0].push_back(ent(8'h41, 1'b0, 0));
    q[0].push_back(ent(8'h42, 1'b0, 0));
    run_traffic("single", 13, 1'b1, 1'b0, 200);
    exp = '{8'h41, 8'h42};
    check_sent("single", exp);
  endtask

  task automatic test_rotation();
    logic [7:0] exp [$];
    do_reset();
    u_frame = 6;
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < N; i++) q[i].push_back(ent(8'h10 + 8'(i), 1'b0, 0));
    run_traffic("rotation", 9, 1'b1, 1'b0, 400);
    for (int j = 0; j < 3 * N; j++) exp.push_back(8'h10 + 8'(j % N));
    check_sent("rotation", exp);
  endtask

  task automatic test_lock();
    logic [7:0] exp [$];
    do_reset();
    u_frame = 5;
    q[2].push_back(ent(8'hA0, 1'b1, 0));
    q[2].push_back(ent(8'hA1, 1'b1, 0));
    q[2].push_back(ent(8'hA2, 1'b0, 0));
    q[0].push_back(ent(8'h55, 1'b0, 1));
    run_traffic("lock", 8, 1'b1, 1'b0, 200);
    exp = '{8'hA0, 8'hA1, 8'hA2, 8'h55};
    check_sent("lock", exp);
  endtask

  task automatic test_stuck_rdy();
    do_reset();
    u_stuck = 1'b1;
    for (int j = 0; j < 4; j++) q[1].push_back(ent(8'($urandom_range(0, 255)), 1'b0, 0));
    run_traffic("stuck_rdy", BT + 3, 1'b1, 1'b0, 200);
    u_stuck = 1'b0;
  endtask

  task automatic test_lock_gap();
    logic [7:0] exp [$];
    do_reset();
    u_frame = 4;
    q[1].push_back(ent(8'h11, 1'b1, 0));
    q[1].push_back(ent(8'hFF, 1'b0, 30));
    q[3].push_back(ent(8'h77, 1'b0, 0));
    run_traffic("lock_gap", 7, 1'b0, 1'b0, 300);
    exp = '{8'h11, 8'hFF, 8'h77};
    check_sent("lock_gap", exp);
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp [$];
    bit         seen;
    do_reset();
    u_frame = 10;
    seen = 1'b0;
    req_valid = 4'b0100;
    req_data[2*DW +: DW] = 8'h5A;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (req_ready !== '0) seen = 1'b1;
      else @(posedge clk);
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL reset_mid first_accept got=none expected=req2");
    end
    @(posedge clk); #1 req_valid = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1 check_idle_outputs("reset_mid");
    @(posedge clk); #1 rst_n = 1'b1;
    model_reset();
    q[1].push_back(ent(8'h33, 1'b0, 0));
    q[3].push_back(ent(8'h99, 1'b0, 0));
    run_traffic("reset_mid", 13, 1'b0, 1'b0, 200);
    exp = '{8'h33, 8'h99};
    check_sent("reset_mid", exp);
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      do_reset();
      u_frame = $urandom_range(1, 8);
      for (int i = 0; i < N; i++) begin
        int n;
        int nb;
        n  = $urandom_range(2, 5);
        nb = 0;
        for (int j = 0; j < n; j++) begin
          nb = nb + $urandom_range(0, 10);
          q[i].push_back(ent(8'($urandom_range(0, 255)), (j != n - 1) && ($urandom_range(0, 2) == 0), nb));
        end
      end
      run_traffic("random", u_frame + 3, 1'b0, 1'b1, 3000);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_lock  = '0;
    model_reset();
    test_reset();
    test_single();
    test_rotation();
    test_lock();
    test_stuck_rdy();
    test_lock_gap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
